// File: rtl/uart_rx_pkg.sv
// Shared types and default sizing for the UART receive controller.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_bit_timer.sv
// Wrapping counter: counts up to i_rollover, then restarts at 1 and flags that
// cycle. The parent switches i_rollover between half-bit and full-bit values.
module bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_rollover,
  output logic             o_rollover_flag
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_rollover;

  assign w_at_rollover   = (r_count == i_rollover);
  assign o_rollover_flag = i_enable && !i_clear && w_at_rollover;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_rollover ? WIDTH'(1) : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: detects start bit, strobes an external LSB-first
// shift register at each bit centre, checks the stop bit and hands off the byte.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS:0]   stp_data,
  output logic                 shift_strobe,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 2);
  // The timer starts from 0 after the clear, so rolling over at half-1 lands
  // on the start-bit centre; the wrap to 1 then aligns the full-bit count.
  localparam logic [TW-1:0] HALF_ROLL = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_ROLL = TW'(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS);

  rx_state_e r_state, w_next_state;

  logic                 r_prev;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_data_ready;
  logic                 r_overrun;
  logic                 r_framing;

  logic          w_falling;
  logic          w_timer_clear;
  logic          w_timer_en;
  logic [TW-1:0] w_rollover;
  logic          w_roll_flag;
  logic          w_start_ok;

  bit_timer #(.WIDTH(TW)) u_bit_timer (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_clear         (w_timer_clear),
    .i_enable        (w_timer_en),
    .i_rollover      (w_rollover),
    .o_rollover_flag (w_roll_flag)
  );

  assign w_falling  = r_prev && !serial_in;
  assign w_start_ok = (r_state == START_CHK) && w_roll_flag && !serial_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_prev  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_prev  <= serial_in;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;
    w_rollover    = FULL_ROLL;
    shift_strobe  = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_clear = 1'b1;
        if (w_falling) w_next_state = START_CHK;
      end
      START_CHK: begin
        w_timer_en = 1'b1;
        w_rollover = HALF_ROLL;
        if (w_roll_flag) w_next_state = serial_in ? IDLE : RECV;
      end
      RECV: begin
        w_timer_en   = 1'b1;
        shift_strobe = w_roll_flag;
        if (w_roll_flag && (r_bit_cnt == LAST_BIT)) w_next_state = STOP_CHK;
      end
      STOP_CHK: w_next_state = stp_data[DATA_BITS] ? LOAD : IDLE;
      LOAD:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= '0;
    end else if (shift_strobe) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data    <= '0;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_framing    <= 1'b0;
    end else begin
      if (w_start_ok) r_framing <= 1'b0;
      if ((r_state == STOP_CHK) && !stp_data[DATA_BITS]) r_framing <= 1'b1;

      // A read landing in LOAD acknowledges the old byte, so no overrun.
      if (r_state == LOAD) begin
        r_rx_data    <= stp_data[DATA_BITS-1:0];
        r_data_ready <= 1'b1;
        if (r_data_ready && !data_read) r_overrun <= 1'b1;
      end else if (data_read) begin
        r_data_ready <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives whole frames, models the external
// shift register, and checks against a frame-level model of the receiver.
module tb_uart_rx_ctrl;

  localparam int CPB    = 10;
  localparam int DB     = 8;
  localparam int HALF   = CPB / 2;
  localparam int FRAME  = CPB * (DB + 2);
  localparam int LOAD_T = HALF + (DB + 1) * CPB + 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          serial_in;
  logic          data_read;
  logic [DB:0]   stp_data = '1;
  logic          shift_strobe;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int strobe_q[$];

  logic [DB-1:0] m_rx;
  logic          m_ready;
  logic          m_ovr;
  logic          m_fe;

  uart_rx_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .stp_data      (stp_data),
    .shift_strobe  (shift_strobe),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External LSB-first serial-to-parallel register: new bit enters at the top.
  always @(posedge clk) if (shift_strobe) stp_data <= {serial_in, stp_data[DB:1]};

  always @(negedge clk) if (shift_strobe) strobe_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rx_data"}, 32'(rx_data), 32'(m_rx));
    check({tag, ".data_ready"}, 32'(data_ready), 32'(m_ready));
    check({tag, ".overrun"}, 32'(overrun_error), 32'(m_ovr));
    check({tag, ".framing"}, 32'(framing_error), 32'(m_fe));
  endtask

  task automatic check_strobes(input string tag, input int e, input int n_exp);
    check({tag, ".strobe_count"}, 32'(strobe_q.size()), 32'(n_exp));
    for (int k = 0; k < strobe_q.size() && k < n_exp; k++)
      check({tag, ".strobe_time"}, 32'(strobe_q[k]), 32'(e + HALF + (k + 1) * CPB));
  endtask

  // Drives one frame; data_read pulses at offset read_at, reset asserts at abort_at.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int read_at,
                            input int abort_at, output int e);
    logic [DB+1:0] line_bits;
    line_bits = {stop, d, 1'b0};
    strobe_q.delete();
    e = 0;
    for (int t = 0; t < FRAME; t++) begin
      @(posedge clk); #1;
      if (t == 0) e = cyc;
      serial_in = line_bits[t / CPB];
      data_read = (t == read_at);
      if (t == abort_at) begin
        n_rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (t == LOAD_T) begin
        check("pre_load.data_ready", 32'(data_ready), 32'(m_ready));
        check("pre_load.rx_data", 32'(rx_data), 32'(m_rx));
      end
      if (t == LOAD_T + 1)
        check("latency.data_ready", 32'(data_ready),
              32'(stop ? 1'b1 : ((read_at == LOAD_T) ? 1'b0 : m_ready)));
    end
    @(posedge clk); #1;
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Frame-level reference: outcome of a complete frame from the receiver rules.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop, input int read_at);
    if (!stop) begin
      m_fe = 1'b1;
      if (read_at == LOAD_T) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
    end else begin
      m_fe = 1'b0;
      if (m_ready && read_at != LOAD_T) m_ovr = 1'b1;
      m_rx    = d;
      m_ready = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [DB-1:0] d, input logic stop,
                           input int read_at);
    int e;
    send_frame(d, stop, read_at, -1, e);
    check_strobes(tag, e, DB + 1);
    model_frame(d, stop, read_at);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic read_pulse(input string tag);
    @(posedge clk); #1;
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    int e;
    logic [DB-1:0] d;
    logic          stop;
    int            rd;

    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    m_rx = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    #1;
    check_outputs("reset");
    check("reset.shift_strobe", 32'(shift_strobe), 32'd0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);

    run_frame("good_a5", 8'hA5, 1'b1, -1);

    // Start-bit glitch: low for three cycles only.
    strobe_q.delete();
    @(posedge clk); #1;
    e = cyc;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 serial_in = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_strobes("glitch", e, 0);
    check_outputs("glitch");

    read_pulse("read_after_a5");
    run_frame("bad_stop_3c", 8'h3C, 1'b0, -1);
    run_frame("good_after_fe", 8'($urandom), 1'b1, -1);

    read_pulse("read_before_ovr");
    run_frame("ovr_11", 8'h11, 1'b1, -1);
    run_frame("ovr_22", 8'h22, 1'b1, -1);
    read_pulse("read_clears_ovr");

    run_frame("coinc_first", 8'($urandom), 1'b1, -1);
    run_frame("coinc_second", 8'($urandom), 1'b1, LOAD_T);

    // Reset in the middle of a frame.
    send_frame(8'h77, 1'b1, -1, 50, e);
    #1;
    m_rx = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    check_outputs("abort");
    check("abort.shift_strobe", 32'(shift_strobe), 32'd0);
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    strobe_q.delete();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_strobes("after_abort", e, 0);
    check_outputs("after_abort");
    run_frame("fresh_5a", 8'h5A, 1'b1, -1);

    // Randomized frames; a coincident read is only issued with no overrun pending.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rd   = $urandom_range(0, 2);
      if (rd == 1 && !m_ovr) run_frame("rand_coinc", d, stop, LOAD_T);
      else                   run_frame("rand", d, stop, -1);
      if (rd == 2) read_pulse("rand_read");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
